gpu_bg_block_mover: RTL and testbench

Memory-side controller directly downstream of the GPU pixel backend. It consumes the backend's block-operation code, the exported 16-pixel BG block, its write mask and the load/save block addresses. It saves the finished block to VRAM as masked 32-bit writes, fetches the next block for blending, and pushes it back into the backend as a single-clock import. While a block operation is in flight it freezes the backend pipeline, and it clears the backend's spike and mask state on completion.

---
 rtl/gpu_bg_block_mover.sv | 254 +++++++++++++++++++++++++
 tb/tb_gpu_bg_block_mover.sv | 391 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpu_bg_block_mover.sv
// gpu_bg_block_mover
//
// Memory-side block mover sitting behind the GPU pixel backend. For every
// block operation requested by the backend it saves the exported 16-pixel
// BG block to VRAM as eight masked 32-bit writes. It then fetches the next
// block as eight reads and hands it back to the backend with a one-clock
// import pulse. The backend pipeline is frozen for the whole operation.
// The operation ends with a one-cycle pulse that clears the backend's
// spike and mask state.
//
// Build option:
//   BG_SKIP_EMPTY_WORDS_EN - when defined, save words whose byte enables are
//                            all zero are skipped without a memory command.
//
// Ports:
//   clk, i_nrst                     clock and synchronous active-low reset
//   i_saveBGBlock                   op code: 01 first, 10 next, 11 flush
//   i_writePixelOnNewBlock          op request (OR of the op code bits)
//   i_noblend                       skip the BG load for non-blending primitives
//   i_loadAdr / i_saveAdr           15-bit block addresses {Y[8:0], X[9:4]}
//   i_exportedBGBlock / i_exportedMSKBGBlock   block pixels and written flags
//   o_pausePipeline                 backend freeze request
//   o_resetPipelinePixelStateSpike, o_resetPixelMask   end-of-op pulses
//   o_importBGBlockSingleClock, o_importedBGBlock       loaded block hand-off
//   o_memCmd*, i_memCmdReady        memory command channel (valid/ready)
//   i_memRValid, i_memRData         in-order read beats

module gpu_bg_block_mover #(
    parameter int MEM_ADR_W = 18
) (
    input  logic                 clk,
    input  logic                 i_nrst,
    input  logic [1:0]           i_saveBGBlock,
    input  logic                 i_writePixelOnNewBlock,
    input  logic                 i_noblend,
    input  logic [14:0]          i_loadAdr,
    input  logic [14:0]          i_saveAdr,
    input  logic [255:0]         i_exportedBGBlock,
    input  logic [15:0]          i_exportedMSKBGBlock,
    output logic                 o_pausePipeline,
    output logic                 o_resetPipelinePixelStateSpike,
    output logic                 o_resetPixelMask,
    output logic                 o_importBGBlockSingleClock,
    output logic [255:0]         o_importedBGBlock,
    output logic                 o_memCmdValid,
    input  logic                 i_memCmdReady,
    output logic                 o_memCmdWrite,
    output logic [MEM_ADR_W-1:0] o_memAdr,
    output logic [31:0]          o_memWData,
    output logic [3:0]           o_memByteEn,
    input  logic                 i_memRValid,
    input  logic [31:0]          i_memRData
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SAVE,
        ST_LOAD_REQ,
        ST_LOAD_WAIT,
        ST_DONE,
        ST_HOLD
    } state_t;

    state_t         state;
    state_t         state_next;

    logic [1:0]     code_q;
    logic [14:0]    save_adr_q;
    logic [14:0]    load_adr_q;
    logic [255:0]   blk_q;
    logic [15:0]    msk_q;
    logic           noblend_q;
    logic [2:0]     word_cnt;
    logic [2:0]     cmd_cnt;
    logic [2:0]     beat_cnt;
    logic           import_q;
    logic [255:0]   imported_q;

    logic [3:0]     save_be;
    logic           save_skip;
    logic           save_step;
    logic           load_step;
    logic           beat_take;
    logic           load_after_save;

    // Each 32-bit word carries two pixels, so each mask bit covers two bytes.
    assign save_be = {{2{msk_q[{word_cnt, 1'b1}]}}, {2{msk_q[{word_cnt, 1'b0}]}}};

`ifdef BG_SKIP_EMPTY_WORDS_EN
    assign save_skip = (save_be == 4'b0000);
`else
    assign save_skip = 1'b0;
`endif

    assign save_step       = (state == ST_SAVE) && (save_skip || i_memCmdReady);
    assign load_step       = (state == ST_LOAD_REQ) && i_memCmdReady;
    // Beats are only counted while a load is armed; stray beats are dropped.
    assign beat_take       = i_memRValid && ((state == ST_LOAD_REQ) || (state == ST_LOAD_WAIT));
    assign load_after_save = (code_q == 2'b10) && !noblend_q;

    // State register.
    always_ff @(posedge clk) begin
        if (!i_nrst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. A zero mask means nothing was drawn, so SAVE is bypassed.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (i_writePixelOnNewBlock) begin
                    case (i_saveBGBlock)
                        2'b01:   state_next = i_noblend ? ST_DONE : ST_LOAD_REQ;
                        2'b10: begin
                            if (i_exportedMSKBGBlock != 16'h0000) begin
                                state_next = ST_SAVE;
                            end else begin
                                state_next = i_noblend ? ST_DONE : ST_LOAD_REQ;
                            end
                        end
                        2'b11:   state_next = (i_exportedMSKBGBlock != 16'h0000) ? ST_SAVE : ST_DONE;
                        default: state_next = ST_DONE;
                    endcase
                end
            end
            ST_SAVE: begin
                if (save_step && (word_cnt == 3'd7)) begin
                    state_next = load_after_save ? ST_LOAD_REQ : ST_DONE;
                end
            end
            ST_LOAD_REQ: begin
                if (load_step && (cmd_cnt == 3'd7)) begin
                    state_next = ST_LOAD_WAIT;
                end
            end
            ST_LOAD_WAIT: begin
                // The import pulse cycle is spent here, so DONE always follows it.
                if (import_q) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_HOLD;
            end
            ST_HOLD: begin
                // A code that stays asserted must not retrigger the same op.
                if ((i_saveBGBlock == 2'b00) || (i_saveBGBlock != code_q)) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Output logic. Pause and valid are also gated by reset so that an
    // abandoned op releases the backend and the memory in the reset cycle.
    always_comb begin
        o_pausePipeline                = 1'b0;
        o_resetPipelinePixelStateSpike = 1'b0;
        o_resetPixelMask               = 1'b0;
        o_memCmdValid                  = 1'b0;
        o_memCmdWrite                  = 1'b0;
        o_memAdr                       = '0;
        o_memWData                     = 32'h0000_0000;
        o_memByteEn                    = 4'b0000;
        case (state)
            ST_IDLE: begin
                o_pausePipeline = i_writePixelOnNewBlock;
            end
            ST_SAVE: begin
                o_pausePipeline = 1'b1;
                o_memCmdValid   = !save_skip;
                o_memCmdWrite   = 1'b1;
                o_memAdr        = MEM_ADR_W'({save_adr_q, word_cnt});
                o_memWData      = blk_q[{word_cnt, 5'd0} +: 32];
                o_memByteEn     = save_be;
            end
            ST_LOAD_REQ: begin
                o_pausePipeline = 1'b1;
                o_memCmdValid   = 1'b1;
                o_memAdr        = MEM_ADR_W'({load_adr_q, cmd_cnt});
            end
            ST_LOAD_WAIT: begin
                o_pausePipeline = 1'b1;
            end
            ST_DONE: begin
                o_pausePipeline                = 1'b1;
                o_resetPipelinePixelStateSpike = 1'b1;
                o_resetPixelMask               = 1'b1;
            end
            default: begin
                o_pausePipeline = 1'b0;
            end
        endcase
        if (!i_nrst) begin
            o_pausePipeline = 1'b0;
            o_memCmdValid   = 1'b0;
        end
    end

    assign o_importBGBlockSingleClock = import_q;
    assign o_importedBGBlock          = imported_q;

    // Datapath: request capture, word/command/beat counters and block assembly.
    // The 3-bit counters wrap back to zero after their eighth step.
    always_ff @(posedge clk) begin
        if (!i_nrst) begin
            code_q     <= 2'b00;
            save_adr_q <= 15'h0000;
            load_adr_q <= 15'h0000;
            blk_q      <= '0;
            msk_q      <= 16'h0000;
            noblend_q  <= 1'b0;
            word_cnt   <= 3'd0;
            cmd_cnt    <= 3'd0;
            beat_cnt   <= 3'd0;
            import_q   <= 1'b0;
            imported_q <= '0;
        end else begin
            import_q <= 1'b0;
            if (state == ST_IDLE) begin
                word_cnt <= 3'd0;
                cmd_cnt  <= 3'd0;
                beat_cnt <= 3'd0;
                if (i_writePixelOnNewBlock) begin
                    code_q     <= i_saveBGBlock;
                    save_adr_q <= i_saveAdr;
                    load_adr_q <= i_loadAdr;
                    blk_q      <= i_exportedBGBlock;
                    msk_q      <= i_exportedMSKBGBlock;
                    noblend_q  <= i_noblend;
                end
            end
            if (save_step) begin
                word_cnt <= word_cnt + 3'd1;
            end
            if (load_step) begin
                cmd_cnt <= cmd_cnt + 3'd1;
            end
            if (beat_take) begin
                imported_q[{beat_cnt, 5'd0} +: 32] <= i_memRData;
                beat_cnt <= beat_cnt + 3'd1;
                if (beat_cnt == 3'd7) begin
                    import_q <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_gpu_bg_block_mover.sv
// tb_gpu_bg_block_mover
//
// Directed testbench for gpu_bg_block_mover. A small VRAM model answers the
// command channel (configurable read latency and ready pattern) and logs
// every accepted write and read. Directed ops are then checked against
// hand-computed addresses, data, byte enables and pulse ordering.
// Expected save counts follow BG_SKIP_EMPTY_WORDS_EN when it is defined.

module tb_gpu_bg_block_mover;

    localparam int MEM_ADR_W = 18;

`ifdef BG_SKIP_EMPTY_WORDS_EN
    localparam int EXP_WR_HALF = 4;
    localparam int EXP_WR_ONE  = 1;
`else
    localparam int EXP_WR_HALF = 8;
    localparam int EXP_WR_ONE  = 8;
`endif

    logic                 clk = 1'b0;
    logic                 i_nrst;
    logic [1:0]           i_saveBGBlock;
    logic                 i_writePixelOnNewBlock;
    logic                 i_noblend;
    logic [14:0]          i_loadAdr;
    logic [14:0]          i_saveAdr;
    logic [255:0]         i_exportedBGBlock;
    logic [15:0]          i_exportedMSKBGBlock;
    logic                 o_pausePipeline;
    logic                 o_resetPipelinePixelStateSpike;
    logic                 o_resetPixelMask;
    logic                 o_importBGBlockSingleClock;
    logic [255:0]         o_importedBGBlock;
    logic                 o_memCmdValid;
    logic                 i_memCmdReady;
    logic                 o_memCmdWrite;
    logic [MEM_ADR_W-1:0] o_memAdr;
    logic [31:0]          o_memWData;
    logic [3:0]           o_memByteEn;
    logic                 i_memRValid;
    logic [31:0]          i_memRData;

    gpu_bg_block_mover #(.MEM_ADR_W(MEM_ADR_W)) dut (
        .clk                            (clk),
        .i_nrst                         (i_nrst),
        .i_saveBGBlock                  (i_saveBGBlock),
        .i_writePixelOnNewBlock         (i_writePixelOnNewBlock),
        .i_noblend                      (i_noblend),
        .i_loadAdr                      (i_loadAdr),
        .i_saveAdr                      (i_saveAdr),
        .i_exportedBGBlock              (i_exportedBGBlock),
        .i_exportedMSKBGBlock           (i_exportedMSKBGBlock),
        .o_pausePipeline                (o_pausePipeline),
        .o_resetPipelinePixelStateSpike (o_resetPipelinePixelStateSpike),
        .o_resetPixelMask               (o_resetPixelMask),
        .o_importBGBlockSingleClock     (o_importBGBlockSingleClock),
        .o_importedBGBlock              (o_importedBGBlock),
        .o_memCmdValid                  (o_memCmdValid),
        .i_memCmdReady                  (i_memCmdReady),
        .o_memCmdWrite                  (o_memCmdWrite),
        .o_memAdr                       (o_memAdr),
        .o_memWData                     (o_memWData),
        .o_memByteEn                    (o_memByteEn),
        .i_memRValid                    (i_memRValid),
        .i_memRData                     (i_memRData)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    // Memory model configuration and logs.
    int                   cyc = 0;
    int                   mem_lat = 3;
    int                   ready_mode = 0;
    logic [3:0]           ready_pat = 4'b1001;
    logic                 rdy;
    int                   rq_due[$];
    logic [31:0]          rq_data[$];
    logic [MEM_ADR_W-1:0] wr_adr[$];
    logic [31:0]          wr_data[$];
    logic [3:0]           wr_be[$];
    logic [MEM_ADR_W-1:0] rd_adr[$];
    int                   beats_seen;
    int                   import_count;
    int                   spike_count;
    int                   rmask_count;
    int                   import_cyc;
    int                   spike_cyc;
    int                   import_nopause;
    int                   stall_err;
    logic [255:0]         imp_block;
    logic                 prev_stall;
    logic [MEM_ADR_W-1:0] prev_adr;
    logic [31:0]          prev_data;
    logic [3:0]           prev_be;

    task automatic checkOutput(input string tag, input logic [255:0] actual, input logic [255:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", tag, actual, expected);
        end
    endtask

    function automatic logic [255:0] pixBlock(input logic [15:0] seed);
        logic [255:0] b;
        for (int n = 0; n < 16; n++) begin
            b[16*n +: 16] = seed + 16'(n);
        end
        return b;
    endfunction

    function automatic logic [31:0] expWord(input logic [15:0] seed, input int w);
        return {seed + 16'(2*w + 1), seed + 16'(2*w)};
    endfunction

    function automatic logic [255:0] loadBlock();
        logic [255:0] b;
        for (int k = 0; k < 8; k++) begin
            b[32*k +: 32] = 32'h1111_1111 * k;
        end
        return b;
    endfunction

    task automatic clearLogs();
        wr_adr.delete();
        wr_data.delete();
        wr_be.delete();
        rd_adr.delete();
        beats_seen     = 0;
        import_count   = 0;
        spike_count    = 0;
        rmask_count    = 0;
        import_cyc     = 0;
        spike_cyc      = 0;
        import_nopause = 0;
        stall_err      = 0;
        imp_block      = '0;
    endtask

    // Presents one op request, checks the same-cycle pause and that the
    // first memory command appears one cycle later. The code stays asserted.
    task automatic applyStimulus(input logic [1:0] code, input logic nb, input logic [14:0] ladr,
                                 input logic [14:0] sadr, input logic [15:0] msk,
                                 input logic [255:0] blk, input string tag);
        clearLogs();
        @(negedge clk);
        i_saveBGBlock          = code;
        i_writePixelOnNewBlock = |code;
        i_noblend              = nb;
        i_loadAdr              = ladr;
        i_saveAdr              = sadr;
        i_exportedMSKBGBlock   = msk;
        i_exportedBGBlock      = blk;
        #1;
        checkOutput({tag, " pause_in_request_cycle"}, 256'(o_pausePipeline), 256'(1));
        checkOutput({tag, " no_cmd_in_request_cycle"}, 256'(o_memCmdValid), 256'(0));
        @(negedge clk);
        #1;
        checkOutput({tag, " first_cmd_next_cycle"}, 256'(o_memCmdValid), 256'(1));
    endtask

    task automatic releaseRequest();
        i_saveBGBlock          = 2'b00;
        i_writePixelOnNewBlock = 1'b0;
    endtask

    task automatic waitDone(input string tag);
        int n = 0;
        while (spike_count == 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, " op_completed"}, 256'(spike_count != 0), 256'(1));
        repeat (4) @(negedge clk);
    endtask

    // Memory model: drives ready and read beats for the next edge, then logs
    // what that edge will accept and watches the backend-facing pulses.
    initial begin
        i_memCmdReady = 1'b1;
        i_memRValid   = 1'b0;
        i_memRData    = 32'h0;
        prev_stall    = 1'b0;
        prev_adr      = '0;
        prev_data     = 32'h0;
        prev_be       = 4'h0;
        forever begin
            @(negedge clk);
            cyc++;
            rdy = (ready_mode == 0) ? 1'b1 : ready_pat[cyc % 4];
            i_memCmdReady = rdy;
            if (rq_due.size() > 0 && rq_due[0] <= cyc) begin
                i_memRValid = 1'b1;
                i_memRData  = rq_data.pop_front();
                rq_due.delete(0);
                beats_seen++;
            end else begin
                i_memRValid = 1'b0;
                i_memRData  = 32'h0;
            end
            if (prev_stall) begin
                if (!o_memCmdValid || o_memAdr !== prev_adr || o_memWData !== prev_data ||
                    o_memByteEn !== prev_be) begin
                    stall_err++;
                end
            end
            prev_stall = o_memCmdValid && !rdy;
            prev_adr   = o_memAdr;
            prev_data  = o_memWData;
            prev_be    = o_memByteEn;
            if (o_memCmdValid && rdy) begin
                if (o_memCmdWrite) begin
                    wr_adr.push_back(o_memAdr);
                    wr_data.push_back(o_memWData);
                    wr_be.push_back(o_memByteEn);
                end else begin
                    rd_adr.push_back(o_memAdr);
                    rq_due.push_back(cyc + mem_lat);
                    rq_data.push_back(32'h1111_1111 * int'(o_memAdr[2:0]));
                end
            end
            if (o_importBGBlockSingleClock) begin
                import_count++;
                import_cyc = cyc;
                imp_block  = o_importedBGBlock;
                if (!o_pausePipeline) import_nopause++;
            end
            if (o_resetPipelinePixelStateSpike) begin
                spike_count++;
                spike_cyc = cyc;
            end
            if (o_resetPixelMask) rmask_count++;
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish, actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        i_nrst                 = 1'b0;
        i_saveBGBlock          = 2'b00;
        i_writePixelOnNewBlock = 1'b0;
        i_noblend              = 1'b0;
        i_loadAdr              = 15'h0;
        i_saveAdr              = 15'h0;
        i_exportedBGBlock      = '0;
        i_exportedMSKBGBlock   = 16'h0;
        clearLogs();

        // Reset state.
        repeat (3) @(negedge clk);
        #1;
        checkOutput("reset pause", 256'(o_pausePipeline), 256'(0));
        checkOutput("reset cmd_valid", 256'(o_memCmdValid), 256'(0));
        checkOutput("reset import", 256'(o_importBGBlockSingleClock), 256'(0));
        checkOutput("reset spike", 256'(o_resetPipelinePixelStateSpike), 256'(0));
        checkOutput("reset adr", 256'(o_memAdr), 256'(0));
        checkOutput("reset imported_block", o_importedBGBlock, 256'(0));
        @(negedge clk);
        i_nrst = 1'b1;
        repeat (2) @(negedge clk);

        // Code 01: load only, latency 3.
        mem_lat = 3;
        applyStimulus(2'b01, 1'b0, 15'h0ABC, 15'h1111, 16'hFFFF, pixBlock(16'h3000), "op01");
        releaseRequest();
        waitDone("op01");
        checkOutput("op01 read_count", 256'(rd_adr.size()), 256'(8));
        for (int k = 0; k < 8; k++) begin
            if (k < rd_adr.size()) checkOutput($sformatf("op01 read_adr%0d", k), 256'(rd_adr[k]), 256'({15'h0ABC, 3'(k)}));
        end
        checkOutput("op01 write_count", 256'(wr_adr.size()), 256'(0));
        checkOutput("op01 imported_word1", 256'(imp_block[63:32]), 256'(32'h1111_1111));
        checkOutput("op01 imported_block", imp_block, loadBlock());
        checkOutput("op01 import_count", 256'(import_count), 256'(1));
        checkOutput("op01 mask_pulse_count", 256'(rmask_count), 256'(1));
        checkOutput("op01 import_before_reset", 256'(spike_cyc > import_cyc), 256'(1));
        checkOutput("op01 pause_during_import", 256'(import_nopause), 256'(0));

        // Code 10: half mask save then load.
        applyStimulus(2'b10, 1'b0, 15'h0042, 15'h1234, 16'h00FF, pixBlock(16'hA000), "op10");
        releaseRequest();
        waitDone("op10");
        checkOutput("op10 write_count", 256'(wr_adr.size()), 256'(EXP_WR_HALF));
        for (int w = 0; w < EXP_WR_HALF; w++) begin
            if (w < wr_adr.size()) begin
                checkOutput($sformatf("op10 write_adr%0d", w), 256'(wr_adr[w]), 256'({15'h1234, 3'(w)}));
                checkOutput($sformatf("op10 write_data%0d", w), 256'(wr_data[w]), 256'(expWord(16'hA000, w)));
                checkOutput($sformatf("op10 write_be%0d", w), 256'(wr_be[w]), 256'((w < 4) ? 4'hF : 4'h0));
            end
        end
        checkOutput("op10 read_count", 256'(rd_adr.size()), 256'(8));
        for (int k = 0; k < 8; k++) begin
            if (k < rd_adr.size()) checkOutput($sformatf("op10 read_adr%0d", k), 256'(rd_adr[k]), 256'({15'h0042, 3'(k)}));
        end
        checkOutput("op10 imported_block", imp_block, loadBlock());

        // Code 10, single pixel, no blend.
        applyStimulus(2'b10, 1'b1, 15'h0055, 15'h0001, 16'h0001, pixBlock(16'hA000), "op10m1");
        releaseRequest();
        waitDone("op10m1");
        checkOutput("op10m1 write_count", 256'(wr_adr.size()), 256'(EXP_WR_ONE));
        checkOutput("op10m1 word0_be", 256'(wr_be[0]), 256'(4'b0011));
        checkOutput("op10m1 word0_data", 256'(wr_data[0]), 256'(32'hA001_A000));
        checkOutput("op10m1 word0_adr", 256'(wr_adr[0]), 256'(18'h00008));
        checkOutput("op10m1 read_count", 256'(rd_adr.size()), 256'(0));
        checkOutput("op10m1 import_count", 256'(import_count), 256'(0));

        // Code 11 held for 20 cycles.
        applyStimulus(2'b11, 1'b0, 15'h0000, 15'h7FFF, 16'hFFFF, pixBlock(16'h0100), "op11");
        repeat (18) @(negedge clk);
        #1;
        checkOutput("op11 hold_pause_low", 256'(o_pausePipeline), 256'(0));
        checkOutput("op11 one_spike_while_held", 256'(spike_count), 256'(1));
        checkOutput("op11 write_count", 256'(wr_adr.size()), 256'(8));
        checkOutput("op11 first_adr", 256'(wr_adr[0]), 256'(18'h3FFF8));
        checkOutput("op11 last_adr", 256'(wr_adr[7]), 256'(18'h3FFFF));
        checkOutput("op11 read_count", 256'(rd_adr.size()), 256'(0));
        releaseRequest();
        waitDone("op11");
        checkOutput("op11 one_spike_after_release", 256'(spike_count), 256'(1));
        checkOutput("op11 mask_pulse_count", 256'(rmask_count), 256'(1));

        // Ready toggling 1,0,0,1 during SAVE.
        ready_mode = 1;
        applyStimulus(2'b11, 1'b0, 15'h0000, 15'h0155, 16'hFFFF, pixBlock(16'h5A00), "stall");
        releaseRequest();
        waitDone("stall");
        ready_mode = 0;
        checkOutput("stall write_count", 256'(wr_adr.size()), 256'(8));
        checkOutput("stall stable_while_stalled", 256'(stall_err), 256'(0));
        for (int w = 0; w < 8; w++) begin
            if (w < wr_adr.size()) begin
                checkOutput($sformatf("stall write_adr%0d", w), 256'(wr_adr[w]), 256'({15'h0155, 3'(w)}));
                checkOutput($sformatf("stall write_data%0d", w), 256'(wr_data[w]), 256'(expWord(16'h5A00, w)));
            end
        end

        // Reset during LOAD_WAIT after three beats.
        mem_lat = 12;
        applyStimulus(2'b01, 1'b0, 15'h0300, 15'h0000, 16'h0000, '0, "rst");
        releaseRequest();
        begin
            int n = 0;
            while (beats_seen < 3 && n < 200) begin
                @(negedge clk);
                #2;
                n++;
            end
        end
        checkOutput("rst three_beats_returned", 256'(beats_seen), 256'(3));
        @(negedge clk);
        #2;
        i_nrst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("rst pause", 256'(o_pausePipeline), 256'(0));
        checkOutput("rst cmd_valid", 256'(o_memCmdValid), 256'(0));
        checkOutput("rst import", 256'(o_importBGBlockSingleClock), 256'(0));
        checkOutput("rst spike", 256'(o_resetPipelinePixelStateSpike), 256'(0));
        checkOutput("rst mask_pulse", 256'(o_resetPixelMask), 256'(0));
        checkOutput("rst cmd_signals", 256'({o_memCmdWrite, o_memByteEn, o_memWData, o_memAdr}), 256'(0));
        checkOutput("rst imported_block", o_importedBGBlock, 256'(0));
        @(negedge clk);
        i_nrst = 1'b1;
        repeat (20) @(negedge clk);
        #1;
        checkOutput("rst stale_beats_ignored", o_importedBGBlock, 256'(0));
        checkOutput("rst no_import_after_reset", 256'(import_count), 256'(0));
        checkOutput("rst idle_pause_low", 256'(o_pausePipeline), 256'(0));
        mem_lat = 3;
        applyStimulus(2'b01, 1'b0, 15'h0007, 15'h0000, 16'h0000, '0, "rst_op01");
        releaseRequest();
        waitDone("rst_op01");
        checkOutput("rst_op01 read_count", 256'(rd_adr.size()), 256'(8));
        checkOutput("rst_op01 first_read_adr", 256'(rd_adr[0]), 256'({15'h0007, 3'd0}));
        checkOutput("rst_op01 imported_block", imp_block, loadBlock());
        checkOutput("rst_op01 import_count", 256'(import_count), 256'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
